// File: rtl/mem_arbiter_if.sv
// Bus bundle for the fetch / load-store / memory sides of mem_arbiter.
// master: the arbiter's view. slave: the surrounding core and memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    instr_req_i;
  logic [ADDR_WIDTH-1:0]   instr_addr_i;
  logic                    instr_gnt_o;
  logic                    instr_rvalid_o;
  logic [DATA_WIDTH-1:0]   instr_rdata_o;

  logic                    data_req_i;
  logic                    data_we_i;
  logic [DATA_WIDTH/8-1:0] data_be_i;
  logic [ADDR_WIDTH-1:0]   data_addr_i;
  logic [DATA_WIDTH-1:0]   data_wdata_i;
  logic                    data_gnt_o;
  logic                    data_rvalid_o;
  logic [DATA_WIDTH-1:0]   data_rdata_o;

  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  modport master (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch vs. load/store arbiter onto one memory bus, one access in flight.
// Data wins by default; a saturating counter forces a fetch through after
// STARVE_LIMIT data grants while a fetch waits. A stalled request keeps
// ownership of the bus until granted so the address never changes mid-stall.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.master  bus,
  output logic           busy_o
);
  localparam int         BE_W   = DATA_WIDTH / 8;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_I = 2'd1;
  localparam logic [1:0] WAIT_D = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  logic [1:0] state, state_nxt;
  logic       lock_vld, lock_instr;
  logic [3:0] starve_cnt;
  logic       idle, sel_i, sel_d, gnt_i, gnt_d;

  assign idle = (state == IDLE);

  // Owner selection in IDLE: lock, then starvation override, then data, then fetch
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (idle && !rst) begin
      if (lock_vld) begin
        sel_i = lock_instr;
        sel_d = !lock_instr;
      end else if (bus.data_req_i && bus.instr_req_i && starve_cnt == LIMIT) begin
        sel_i = 1'b1;
      end else if (bus.data_req_i) begin
        sel_d = 1'b1;
      end else if (bus.instr_req_i) begin
        sel_i = 1'b1;
      end
    end
  end

  // Bus mux and grant/response routing; everything quiet while in reset
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (sel_i) begin
      bus.mem_req_o  = bus.instr_req_i;
      bus.mem_be_o   = {BE_W{1'b1}};
      bus.mem_addr_o = bus.instr_addr_i;
    end else if (sel_d) begin
      bus.mem_req_o   = bus.data_req_i;
      bus.mem_we_o    = bus.data_we_i;
      bus.mem_be_o    = bus.data_be_i;
      bus.mem_addr_o  = bus.data_addr_i;
      bus.mem_wdata_o = bus.data_wdata_i;
    end
    gnt_i = sel_i & bus.mem_req_o & bus.mem_gnt_i;
    gnt_d = sel_d & bus.mem_req_o & bus.mem_gnt_i;
    bus.instr_gnt_o    = gnt_i;
    bus.data_gnt_o     = gnt_d;
    bus.instr_rvalid_o = !rst && state == WAIT_I && bus.mem_rvalid_i;
    bus.data_rvalid_o  = !rst && state == WAIT_D && bus.mem_rvalid_i;
    bus.instr_rdata_o  = bus.mem_rdata_i;
    bus.data_rdata_o   = bus.mem_rdata_i;
  end

  // Next state: grant opens a wait, rvalid closes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_i) state_nxt = WAIT_I;
               else if (gnt_d) state_nxt = WAIT_D;
      WAIT_I,
      WAIT_D:  if (bus.mem_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner lock and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lock_vld   <= 1'b0;
      lock_instr <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_i || gnt_d) begin
        lock_vld <= 1'b0;
      end else if (bus.mem_req_o) begin
        lock_vld   <= 1'b1;
        lock_instr <= sel_i;
      end
      if (gnt_i || (idle && !bus.instr_req_i))
        starve_cnt <= '0;
      else if (gnt_d && bus.instr_req_i && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign busy_o = !idle;
endmodule
